// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store.
// Data has priority; fetch is granted after STARVE_LIMIT contested losses.
module mem_port_arbiter #(
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        d_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_own_d;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wmask;
  logic [TW-1:0] r_tcnt;
  logic [SW-1:0] r_starve;
  logic          r_if_rv;
  logic          r_if_err;
  logic [31:0]   r_if_rdata;
  logic          r_d_rv;
  logic          r_d_err;
  logic [31:0]   r_d_rdata;

  logic w_idle;
  logic w_busy;
  logic w_if_win;
  logic w_d_win;
  logic w_grant;
  logic w_expire;
  logic w_done;
  logic w_fin;

  assign w_idle   = (r_state == S_IDLE);
  assign w_busy   = !w_idle;
  assign w_if_win = w_idle && if_req &&
                    (!d_req || (r_starve == SMAX));
  assign w_d_win  = w_idle && d_req && !w_if_win;
  assign w_grant  = w_if_win || w_d_win;
  // A response in the expiry cycle beats the timeout.
  assign w_expire = (TIMEOUT != 0) && w_busy &&
                    (r_tcnt == TLAST);
  assign w_done   = (r_state == S_WAIT) && mem_resp_valid;
  assign w_fin    = w_done || w_expire;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_expire)     w_next = S_IDLE;
        else if (mem_ack) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_fin) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_own_d    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_tcnt     <= '0;
      r_starve   <= '0;
      r_if_rv    <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= '0;
      r_d_rv     <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rdata  <= '0;
    end else begin
      r_state  <= w_next;
      r_if_rv  <= 1'b0;
      r_if_err <= 1'b0;
      r_d_rv   <= 1'b0;
      r_d_err  <= 1'b0;
      if (w_grant) begin
        r_own_d <= w_d_win;
        r_addr  <= w_d_win ? d_addr : if_addr;
        r_wdata <= w_d_win ? d_wdata : '0;
        r_wmask <= w_d_win ? d_wmask : '0;
        r_tcnt  <= '0;
      end else if (w_busy) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_fin) begin
        if (r_own_d) begin
          r_d_rv    <= 1'b1;
          r_d_err   <= !w_done;
          r_d_rdata <= w_done ? mem_rdata : '0;
        end else begin
          r_if_rv    <= 1'b1;
          r_if_err   <= !w_done;
          r_if_rdata <= w_done ? mem_rdata : '0;
        end
      end
      if (w_d_win && if_req) begin
        if (r_starve != SMAX) r_starve <= r_starve + 1'b1;
      end else if (w_if_win || !if_req) begin
        r_starve <= '0;
      end
    end
  end

  // Ready is combinational, so gate it while reset holds outputs low.
  assign if_ready      = w_if_win && !reset;
  assign d_ready       = w_d_win && !reset;
  assign if_resp_valid = r_if_rv;
  assign if_err        = r_if_err;
  assign if_resp_data  = r_if_rdata;
  assign d_resp_valid  = r_d_rv;
  assign d_err         = r_d_err;
  assign d_resp_data   = r_d_rdata;
  assign mem_req       = (r_state == S_ISSUE);
  assign mem_addr      = mem_req ? (r_addr & 32'hFFFF_FFFC) : '0;
  assign mem_wdata     = mem_req ? r_wdata : '0;
  assign mem_wmask     = mem_req ? r_wmask : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model, random traffic,
// and directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int TO = 8;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wmask = '0;
  logic        mem_ack = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        if_ready, if_resp_valid, if_err;
  logic [31:0] if_resp_data;
  logic        d_ready, d_resp_valid, d_err;
  logic [31:0] d_resp_data;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  mem_port_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_ready(d_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Knobs set by the scenario sequence.
  int          if_mode = 0;
  int          d_mode = 0;
  int          mem_mode = 0;
  int          stale_en = 0;
  int          ack_lat = 0;
  int          resp_lat = 1;
  bit          never_resp = 0;
  bit          force_resp = 0;
  logic [31:0] rdata_k = 32'hDEADBEEF;
  int          if_shot_n = 0;
  int          d_shot_n = 0;
  logic [31:0] shot_if_addr = '0;
  logic [31:0] shot_d_addr = '0;
  logic [31:0] shot_d_wdata = '0;
  logic [3:0]  shot_d_wmask = '0;

  // Reference model: one transaction in flight, tracked by age.
  bit          m_busy, m_acked, m_own_d, m_if_acc, m_d_acc;
  int          m_age, m_losses;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;
  bit          m_if_rv, m_if_err, m_d_rv, m_d_err;
  logic [31:0] m_if_data, m_d_data;

  logic        e_if_ready, e_d_ready, e_mem_req;
  logic [31:0] e_mem_addr, e_mem_wdata;
  logic [3:0]  e_mem_wmask;

  always_comb begin
    e_if_ready  = 1'b0;
    e_d_ready   = 1'b0;
    if (!reset && !m_busy) begin
      if (if_req && (!d_req || m_losses == SL)) e_if_ready = 1'b1;
      else if (d_req) e_d_ready = 1'b1;
    end
    e_mem_req   = m_busy && !m_acked;
    e_mem_addr  = e_mem_req ? {m_addr[31:2], 2'b00} : 32'h0;
    e_mem_wdata = e_mem_req ? m_wdata : 32'h0;
    e_mem_wmask = e_mem_req ? m_wmask : 4'h0;
  end

  bit          f_fin, f_err;
  logic [31:0] f_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_acked <= 0; m_own_d <= 0;
      m_if_acc <= 0; m_d_acc <= 0; m_age <= 0; m_losses <= 0;
      m_addr <= 0; m_wdata <= 0; m_wmask <= 0;
      m_if_rv <= 0; m_if_err <= 0; m_if_data <= 0;
      m_d_rv <= 0; m_d_err <= 0; m_d_data <= 0;
    end else begin
      f_fin = 0; f_err = 0; f_data = 0;
      m_if_rv <= 0; m_if_err <= 0; m_d_rv <= 0; m_d_err <= 0;
      m_if_acc <= e_if_ready;
      m_d_acc  <= e_d_ready;
      if (!m_busy) begin
        if (e_if_ready || e_d_ready) begin
          m_busy  <= 1; m_acked <= 0; m_age <= 0;
          m_own_d <= e_d_ready;
          m_addr  <= e_d_ready ? d_addr : if_addr;
          m_wdata <= e_d_ready ? d_wdata : 32'h0;
          m_wmask <= e_d_ready ? d_wmask : 4'h0;
        end
      end else if (m_acked && mem_resp_valid) begin
        f_fin = 1; f_data = mem_rdata;
      end else if (TO != 0 && m_age + 1 == TO) begin
        f_fin = 1; f_err = 1;
      end else begin
        m_age <= m_age + 1;
        if (!m_acked && mem_ack) m_acked <= 1;
      end
      if (f_fin) begin
        m_busy <= 0;
        if (m_own_d) begin
          m_d_rv <= 1; m_d_err <= f_err; m_d_data <= f_data;
        end else begin
          m_if_rv <= 1; m_if_err <= f_err; m_if_data <= f_data;
        end
      end
      if (e_d_ready && if_req) m_losses <= (m_losses < SL) ? m_losses + 1 : SL;
      else if (e_if_ready || !if_req) m_losses <= 0;
    end
  end

  // Stimulus driver: requesters hold until accepted, memory reacts to model.
  int if_shot_done = 0;
  int d_shot_done = 0;
  int ack_cnt = 0;
  int rsp_cnt = 0;
  int cur_ack = 0;
  int cur_rsp = 1;

  always @(posedge clk) begin
    #1;
    if (m_if_acc) if_req = 0;
    if (if_mode == 0) if_req = 0;
    else if (if_mode == 1) begin
      if (!if_req) begin
        if ($urandom_range(0, 1) == 1) begin
          if_req = 1; if_addr = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) if_req = 0;
    end else if (if_mode == 2) begin
      if (!if_req && if_shot_n != if_shot_done) begin
        if_req = 1; if_addr = shot_if_addr; if_shot_done = if_shot_n;
      end
    end else if (!if_req) begin
      if_req = 1; if_addr = $urandom;
    end

    if (m_d_acc) d_req = 0;
    if (d_mode == 0) d_req = 0;
    else if (d_mode == 1) begin
      if (!d_req) begin
        if ($urandom_range(0, 1) == 1) begin
          d_req = 1; d_addr = $urandom; d_wdata = $urandom;
          d_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        end
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
    end else if (d_mode == 2) begin
      if (!d_req && d_shot_n != d_shot_done) begin
        d_req = 1; d_addr = shot_d_addr; d_wdata = shot_d_wdata;
        d_wmask = shot_d_wmask; d_shot_done = d_shot_n;
      end
    end else if (!d_req) begin
      d_req = 1; d_addr = $urandom; d_wdata = $urandom;
      d_wmask = 4'($urandom);
    end

    mem_ack = 0;
    mem_resp_valid = 0;
    mem_rdata = (mem_mode == 1) ? $urandom : rdata_k;
    if (!m_busy) begin
      ack_cnt = 0; rsp_cnt = 0;
      if (mem_mode == 1) begin
        cur_ack = ($urandom_range(0, 15) == 0) ? 9 : $urandom_range(0, 2);
        cur_rsp = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(1, 3);
      end else begin
        cur_ack = ack_lat; cur_rsp = resp_lat;
      end
      if (stale_en == 2 || (stale_en == 1 && $urandom_range(0, 3) == 0))
        mem_resp_valid = 1;
    end else if (!m_acked) begin
      if (ack_cnt >= cur_ack) begin
        mem_ack = 1; rsp_cnt = 0;
      end else ack_cnt++;
      if (stale_en == 1 && $urandom_range(0, 7) == 0) mem_resp_valid = 1;
    end else begin
      rsp_cnt++;
      if (!never_resp && rsp_cnt >= cur_rsp) mem_resp_valid = 1;
    end
    if (force_resp) mem_resp_valid = 1;
  end

  always @(negedge clk) begin
    chk("if_ready", if_ready, e_if_ready);
    chk("d_ready", d_ready, e_d_ready);
    chk("if_resp_valid", if_resp_valid, m_if_rv);
    chk("if_err", if_err, m_if_err);
    chk("if_resp_data", if_resp_data, m_if_data);
    chk("d_resp_valid", d_resp_valid, m_d_rv);
    chk("d_err", d_err, m_d_err);
    chk("d_resp_data", d_resp_data, m_d_data);
    chk("mem_req", mem_req, e_mem_req);
    chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("mem_wmask", mem_wmask, e_mem_wmask);
  end

  task automatic wait_ready(input bit is_d, input string nm);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_d ? d_ready : if_ready) begin
        ok = 1;
        break;
      end
    end
    chk(nm, ok, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, {25'h0, if_ready, d_ready, if_resp_valid,
        if_err, d_resp_valid, d_err, mem_req}, 0);
    chk({nm, "_ifdata"}, if_resp_data, 0);
    chk({nm, "_ddata"}, d_resp_data, 0);
    chk({nm, "_maddr"}, mem_addr, 0);
    chk({nm, "_mwdata"}, mem_wdata, 0);
    chk({nm, "_mwmask"}, {28'h0, mem_wmask}, 0);
  endtask

  int         cnt, pulses;
  bit         stable, found;
  logic [9:0] grants;

  initial begin
    reset = 1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 0;
    repeat (2) @(negedge clk);

    // Single fetch with minimum round trip.
    shot_if_addr = 32'h0000_1006;
    if_mode = 2;
    if_shot_n++;
    wait_ready(0, "fetch_ready");
    @(negedge clk);
    chk("fetch_mreq", mem_req, 1);
    chk("fetch_maddr", mem_addr, 32'h0000_1004);
    chk("fetch_mwmask", mem_wmask, 0);
    repeat (2) @(negedge clk);
    chk("fetch_rv", if_resp_valid, 1);
    chk("fetch_data", if_resp_data, 32'hDEADBEEF);
    chk("fetch_d_quiet", {d_resp_valid, d_err}, 0);
    if_mode = 0;

    // Store with a delayed ack.
    ack_lat = 3;
    repeat (3) @(negedge clk);
    shot_d_addr = 32'h20;
    shot_d_wdata = 32'h0000_AB00;
    shot_d_wmask = 4'b0010;
    d_mode = 2;
    d_shot_n++;
    wait_ready(1, "store_ready");
    cnt = 0; stable = 1; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req) begin
        cnt++;
        if (mem_addr != 32'h20 || mem_wdata != 32'hAB00 ||
            mem_wmask != 4'b0010) stable = 0;
      end
      if (d_resp_valid) pulses++;
    end
    chk("store_mreq_cycles", cnt, 4);
    chk("store_stable", stable, 1);
    chk("store_pulses", pulses, 1);
    d_mode = 0;
    ack_lat = 0;
    repeat (4) @(negedge clk);

    // Both requesters always asking.
    if_mode = 3;
    d_mode = 3;
    grants = '0;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 10; i++) begin
      @(negedge clk);
      if (if_ready) begin
        grants[cnt] = 1'b1;
        cnt++;
      end else if (d_ready) cnt++;
    end
    chk("starve_count", cnt, 10);
    chk("starve_order", {22'h0, grants}, 32'b10_0001_0000);
    if_mode = 0;
    d_mode = 0;
    repeat (6) @(negedge clk);

    // Memory never responds.
    never_resp = 1;
    shot_d_addr = 32'h44;
    shot_d_wdata = 0;
    shot_d_wmask = 0;
    d_mode = 2;
    d_shot_n++;
    wait_ready(1, "tmo_ready");
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_resp_valid) pulses++;
      if (k == 9) begin
        chk("tmo_rv", d_resp_valid, 1);
        chk("tmo_err", d_err, 1);
        chk("tmo_data", d_resp_data, 0);
      end
    end
    chk("tmo_pulses", pulses, 1);
    stale_en = 2;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_resp_valid || if_resp_valid) pulses++;
    end
    chk("stale_pulses", pulses, 0);
    stale_en = 0;
    d_mode = 0;

    // Reset while waiting for a response.
    shot_if_addr = 32'h300;
    if_mode = 2;
    if_shot_n++;
    wait_ready(0, "rst_ready");
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1 chk_all_zero("midreset");
    force_resp = 1;
    pulses = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_resp_valid || if_resp_valid) pulses++;
    end
    chk("rst_pulses", pulses, 0);
    force_resp = 0;
    never_resp = 0;
    rdata_k = 32'h1234_5678;
    shot_if_addr = 32'h404;
    if_shot_n++;
    wait_ready(0, "post_rst_ready");
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_resp_valid) begin
        found = 1;
        break;
      end
    end
    chk("post_rst_rv", found, 1);
    chk("post_rst_data", if_resp_data, 32'h1234_5678);
    chk("post_rst_err", if_err, 0);
    if_mode = 0;
    repeat (3) @(negedge clk);

    // Back-to-back data requests.
    d_mode = 3;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (d_resp_valid && d_ready) found = 1;
    end
    chk("b2b_same_cycle", found, 1);
    d_mode = 0;
    repeat (6) @(negedge clk);

    // Random traffic against the model.
    if_mode = 1;
    d_mode = 1;
    mem_mode = 1;
    stale_en = 1;
    repeat (4000) @(negedge clk);
    if_mode = 0;
    d_mode = 0;
    stale_en = 0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
